// File: rtl/mac_pkg.sv
// Shared types and sizing for the FIFO-fed multiply-accumulate reader.
package mac_pkg;

   // Operation sequencing: wait for start, issue reads, absorb the last product, publish.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Accumulator width that holds depth full-width products without overflow.
   function automatic int acc_width(input int data_width, input int depth);
      return 2 * data_width + $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath: clear, enable-gated accumulate of an unsigned product.
module mac_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [2*DATA_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]    acc_d;
   logic [ACC_WIDTH-1:0]    acc_q;

   // Full-width unsigned product; zero-extending the operands keeps every bit.
   always_comb begin
      prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
   end

   // Clear wins over accumulate; otherwise add the product when enabled.
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_WIDTH'(prod);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/mac_reader.sv
// Reads DEPTH operand pairs from two FIFOs in lockstep and returns the sum of products.
// Handshake: a FIFO word is consumed on every cycle its rden is high (only ever issued
// while both FIFOs report non-empty); the word appears on *_data the following cycle,
// where the one-cycle valid flag lets the accumulator absorb it.
module mac_reader
   import mac_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 8,
   localparam int ACC_WIDTH  = mac_pkg::acc_width(DATA_WIDTH, DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  a_empty,
   input  logic                  b_empty,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  a_rden,
   output logic                  b_rden,
   output logic                  busy,
   output logic                  done,
   output logic [ACC_WIDTH-1:0]  result,
   output state_e                state_dbg
);

   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]   LAST_C  = CW'(DEPTH - 1);

   state_e                 state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   valid_q, valid_d;
   logic [ACC_WIDTH-1:0]   result_q, result_d;
   logic [ACC_WIDTH-1:0]   acc;
   logic                   rden;
   logic                   clr;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start only matters in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (rden && (count_q == LAST_C)) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs; a single rden feeds both FIFOs so pairs never split.
   always_comb begin
      rden = 1'b0;
      clr  = 1'b0;
      done = 1'b0;
      busy = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: clr  = start;
         ST_RUN:  rden = !a_empty && !b_empty && (count_q < DEPTH_C);
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Issue counter, read-data valid flag and published result.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (rden) begin
         count_d = count_q + 1'b1;
      end
      valid_d  = rden;
      result_d = (state_q == ST_DONE) ? acc : result_q;
   end

   // Datapath control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         count_q  <= count_d;
         valid_q  <= valid_d;
         result_q <= result_d;
      end
   end

   mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac_unit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (valid_q),
      .a     (a_data),
      .b     (b_data),
      .acc   (acc)
   );

   // The accumulator is final during DONE, so result shows it in the same cycle as done.
   assign result    = (state_q == ST_DONE) ? acc : result_q;
   assign a_rden    = rden;
   assign b_rden    = rden;
   assign state_dbg = state_q;

endmodule

// File: doc/mac_reader.md
MAC_READER -- requirements
Module: mac_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of each FIFO data word.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of operand pairs consumed per operation.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin an operation.
REQ-006 The block SHALL have ports a_empty and b_empty, input, 1 bit each: empty flags of the operand-A and operand-B FIFOs.
REQ-007 The block SHALL have ports a_data and b_data, input, DATA_WIDTH bits each: FIFO read data, valid the cycle after the matching rden.
REQ-008 The block SHALL have ports a_rden and b_rden, output, 1 bit each: read requests to the two FIFOs.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when result becomes valid.
REQ-011 The block SHALL have port result, output, ACC_WIDTH = 2*DATA_WIDTH + $clog2(DEPTH)+1 bits: unsigned sum of products.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE: start=1 -> accumulator cleared, issue count cleared, next state RUN; otherwise stay.
REQ-014 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-015 RUN: a_rden = b_rden = !a_empty & !b_empty & (count < DEPTH); the two rden SHALL always be equal.
REQ-016 Each cycle with rden high SHALL increment count by 1 and set a one-cycle valid flag for the next cycle.
REQ-017 When the valid flag is high, the accumulator SHALL add a_data*b_data (unsigned, full 2*DATA_WIDTH product, zero-extended).
REQ-018 Only one FIFO empty SHALL stall both reads; no partial pair is ever consumed.
REQ-019 On the cycle the DEPTH-th read issues, next state SHALL be DRAIN.
REQ-020 DRAIN: the final product is accumulated; next state DONE unconditionally (one cycle).
REQ-021 DONE: result SHALL load the accumulator, done=1 for exactly this cycle, next state IDLE.
REQ-022 result SHALL hold its value until the next DONE; it SHALL not change during a subsequent operation.
REQ-023 busy SHALL be high in RUN, DRAIN and DONE, low in IDLE.
REQ-024 Minimum latency with both FIFOs non-empty: start at cycle 0 -> done at cycle DEPTH+2.
REQ-025 ACC_WIDTH SHALL be sized so DEPTH maximal products cannot overflow; no saturation logic.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, count 0, valid flag 0, accumulator 0, result 0, done 0, busy 0, a_rden/b_rden 0.
REQ-027 Reset mid-operation SHALL abandon the operation; no done pulse; FIFO contents already read are lost.

Structure
REQ-028 A shared package mac_pkg SHALL hold the FSM state enum and the ACC_WIDTH computation.
REQ-029 One sub-module, mac_unit, SHALL hold the multiply-accumulate datapath (clear, enable, operands, accumulator out).
REQ-030 FIFO handshake control and FSM SHALL live in mac_reader.

Verification
REQ-031 Both FIFOs preloaded with 1..8, pulse start -> a_rden high cycles 1..8, done at cycle 10, result=204.
REQ-032 All words 8'hFF, DEPTH=8 -> result=8*65025=520200, no overflow.
REQ-033 b_empty held high for 3 cycles mid-RUN -> both rden low those cycles, no reads lost, result unchanged vs REQ-031, done delayed 3 cycles.
REQ-034 start pulsed again during RUN -> ignored; exactly one done; result=204.
REQ-035 rst_n asserted after 4 reads -> all outputs 0 immediately; new start with fresh data 2s*3s -> result=48.
REQ-036 Two back-to-back operations (1..8, then all 1s) -> result 204 held until second done, then 8.
